// File: rtl/cr16_regfile.sv
// cr16_regfile: CR16 general-purpose register file plus processor status
// register (PSR).
//
// Two registered read ports supply the ALU operands (I_A / I_B). One write
// port takes the ALU result (O_C) at writeback. The PSR {N,Z,F,L,C} captures
// the ALU O_STATUS flags under a per-bit update mask.
//
// Ports
//   I_CLK, I_RESET        clock, synchronous active-high reset
//   I_ENABLE              stage enable; low freezes all state and outputs
//   I_RD_ADDR_A/B         read addresses
//   O_RD_DATA_A/B         read data, one cycle after the address
//   I_WR_ENABLE/ADDR/DATA writeback port
//   I_STATUS, I_STATUS_MASK  flag values and per-bit PSR update select
//   O_PSR                 current PSR contents

// Single registered read port. It indexes the *next-state* register array,
// so a same-cycle write to the addressed register is seen write-first
// without a separate bypass compare.
module cr16_regfile_rdport #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_nxt,
  output logic [DATA_WIDTH-1:0]                data
);
  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (en) data_d = regs_nxt[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;
endmodule

module cr16_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FLAG_WIDTH = 5
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  I_ENABLE,
  input  logic [ADDR_WIDTH-1:0] I_RD_ADDR_A,
  input  logic [ADDR_WIDTH-1:0] I_RD_ADDR_B,
  output logic [DATA_WIDTH-1:0] O_RD_DATA_A,
  output logic [DATA_WIDTH-1:0] O_RD_DATA_B,
  input  logic                  I_WR_ENABLE,
  input  logic [ADDR_WIDTH-1:0] I_WR_ADDR,
  input  logic [DATA_WIDTH-1:0] I_WR_DATA,
  input  logic [FLAG_WIDTH-1:0] I_STATUS,
  input  logic [FLAG_WIDTH-1:0] I_STATUS_MASK,
  output logic [FLAG_WIDTH-1:0] O_PSR
);
  localparam int NUM_PORTS = 2;

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_d, regs_q;
  logic [FLAG_WIDTH-1:0]                psr_d, psr_q;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  // Register array and PSR next state. The enable gates everything, so a
  // write strobed during a stall is simply lost.
  always_comb begin
    regs_d = regs_q;
    psr_d  = psr_q;
    if (I_ENABLE) begin
      if (I_WR_ENABLE) regs_d[I_WR_ADDR] = I_WR_DATA;
      psr_d = (I_STATUS & I_STATUS_MASK) | (psr_q & ~I_STATUS_MASK);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      regs_q <= '0;
      psr_q  <= '0;
    end else begin
      regs_q <= regs_d;
      psr_q  <= psr_d;
    end
  end

  assign rd_addr = {I_RD_ADDR_B, I_RD_ADDR_A};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    cr16_regfile_rdport #(
      .DATA_WIDTH(DATA_WIDTH),
      .REG_COUNT (REG_COUNT),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd (
      .clk     (I_CLK),
      .rst     (I_RESET),
      .en      (I_ENABLE),
      .addr    (rd_addr[p]),
      .regs_nxt(regs_d),
      .data    (rd_data[p])
    );
  end

  assign O_RD_DATA_A = rd_data[0];
  assign O_RD_DATA_B = rd_data[1];
  assign O_PSR       = psr_q;
endmodule

// File: tb/tb_cr16_regfile.sv
// Self-checking bench for cr16_regfile: directed vector table, hand-written
// reset / ALU-loop sequences, and randomized traffic against a reference model.
module tb_cr16_regfile;
  logic        I_CLK = 1'b0;
  logic        I_RESET, I_ENABLE, I_WR_ENABLE;
  logic [3:0]  I_RD_ADDR_A, I_RD_ADDR_B, I_WR_ADDR;
  logic [15:0] I_WR_DATA, O_RD_DATA_A, O_RD_DATA_B;
  logic [4:0]  I_STATUS, I_STATUS_MASK, O_PSR;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array + PSR + last read results.
  logic [15:0] m_reg [16];
  logic [4:0]  m_psr;
  logic [15:0] m_a, m_b;

  always #5 I_CLK = ~I_CLK;

  cr16_regfile dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE),
    .I_RD_ADDR_A(I_RD_ADDR_A), .I_RD_ADDR_B(I_RD_ADDR_B),
    .O_RD_DATA_A(O_RD_DATA_A), .O_RD_DATA_B(O_RD_DATA_B),
    .I_WR_ENABLE(I_WR_ENABLE), .I_WR_ADDR(I_WR_ADDR), .I_WR_DATA(I_WR_DATA),
    .I_STATUS(I_STATUS), .I_STATUS_MASK(I_STATUS_MASK), .O_PSR(O_PSR)
  );

  typedef struct {
    logic        en, we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra, rb;
    logic [4:0]  st, mk;
    logic [15:0] exp_a, exp_b;
    logic [4:0]  exp_psr;
  } vec_t;

  vec_t vec [9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model by the spec rules, sample 1ns later.
  task automatic cyc(input logic rst, input logic en, input logic we,
                     input logic [3:0] wa, input logic [15:0] wd,
                     input logic [3:0] ra, input logic [3:0] rb,
                     input logic [4:0] st, input logic [4:0] mk);
    I_RESET = rst; I_ENABLE = en; I_WR_ENABLE = we; I_WR_ADDR = wa;
    I_WR_DATA = wd; I_RD_ADDR_A = ra; I_RD_ADDR_B = rb;
    I_STATUS = st; I_STATUS_MASK = mk;
    @(posedge I_CLK);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
      m_psr = 5'h0; m_a = 16'h0; m_b = 16'h0;
    end else if (en) begin
      m_a = (we && wa == ra) ? wd : m_reg[ra];
      m_b = (we && wa == rb) ? wd : m_reg[rb];
      if (we) m_reg[wa] = wd;
      for (int k = 0; k < 5; k++) if (mk[k]) m_psr[k] = st[k];
    end
    #1;
  endtask

  logic [15:0] alu_a, alu_b, alu_c;
  logic [16:0] alu_sum;
  logic [4:0]  alu_st;

  initial begin
    // Test 1: preload all regs 0xFFFF and PSR 1F, then reset with a write
    // and flag update presented in the reset cycle (must be discarded).
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 1, 4'(i), 16'hFFFF, 0, 0, 5'h1F, 5'h1F);
    cyc(0, 1, 0, 0, 0, 4'h9, 4'hC, 0, 0);
    chk("preload_a", O_RD_DATA_A, 16'hFFFF);
    chk("preload_psr", {11'h0, O_PSR}, 16'h001F);
    cyc(1, 1, 1, 4'h2, 16'h1234, 4'h2, 4'h2, 5'h1F, 5'h1F);
    chk("rst_a", O_RD_DATA_A, 16'h0);
    chk("rst_b", O_RD_DATA_B, 16'h0);
    chk("rst_psr", {11'h0, O_PSR}, 16'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0, 0, 4'(i), 4'(15 - i), 0, 0);
      chk($sformatf("rst_rd_a%0d", i), O_RD_DATA_A, 16'h0);
      chk($sformatf("rst_rd_b%0d", 15 - i), O_RD_DATA_B, 16'h0);
    end

    // Directed vector table (starting from all-zero state).
    //          en we wa     wd        ra     rb     st     mk     exp_a     exp_b     psr
    vec[0] = '{1, 1, 4'h3, 16'h1234, 4'h0, 4'h0, 5'h00, 5'h00, 16'h0000, 16'h0000, 5'h00};
    vec[1] = '{1, 0, 4'h0, 16'h0000, 4'h3, 4'h4, 5'h00, 5'h00, 16'h1234, 16'h0000, 5'h00};
    vec[2] = '{1, 1, 4'h7, 16'h0001, 4'h7, 4'h2, 5'h00, 5'h00, 16'h0001, 16'h0000, 5'h00};
    vec[3] = '{1, 1, 4'h7, 16'hBEEF, 4'h7, 4'h7, 5'h00, 5'h00, 16'hBEEF, 16'hBEEF, 5'h00};
    vec[4] = '{0, 1, 4'h5, 16'hAAAA, 4'h3, 4'h3, 5'h1F, 5'h1F, 16'hBEEF, 16'hBEEF, 5'h00};
    vec[5] = '{1, 0, 4'h0, 16'h0000, 4'h5, 4'h0, 5'h1F, 5'h05, 16'h0000, 16'h0000, 5'h05};
    vec[6] = '{1, 0, 4'h0, 16'h0000, 4'h3, 4'h7, 5'h00, 5'h01, 16'h1234, 16'hBEEF, 5'h04};
    vec[7] = '{1, 1, 4'hF, 16'hFFFF, 4'hF, 4'h0, 5'h1A, 5'h18, 16'hFFFF, 16'h0000, 5'h1C};
    vec[8] = '{1, 1, 4'h0, 16'h5A5A, 4'h0, 4'hF, 5'h00, 5'h00, 16'h5A5A, 16'hFFFF, 5'h1C};
    for (int v = 0; v < 9; v++) begin
      cyc(0, vec[v].en, vec[v].we, vec[v].wa, vec[v].wd, vec[v].ra, vec[v].rb,
          vec[v].st, vec[v].mk);
      chk($sformatf("vec%0d_a", v), O_RD_DATA_A, vec[v].exp_a);
      chk($sformatf("vec%0d_b", v), O_RD_DATA_B, vec[v].exp_b);
      chk($sformatf("vec%0d_psr", v), {11'h0, O_PSR}, {11'h0, vec[v].exp_psr});
    end

    // Multi-cycle stall: several stalled cycles with writes, outputs frozen.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 4'h0, 16'h1111, 4'h1, 4'h1, 5'h1F, 5'h1F);
      chk("stall_hold_a", O_RD_DATA_A, 16'h5A5A);
      chk("stall_hold_psr", {11'h0, O_PSR}, 16'h001C);
    end
    cyc(0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    chk("stall_dropped_r0", O_RD_DATA_A, 16'h5A5A);

    // Test 6: ALU loop, ADD modelled here: R1=0x7FFF + R2=0x0001.
    cyc(0, 1, 1, 4'h1, 16'h7FFF, 0, 0, 0, 0);
    cyc(0, 1, 1, 4'h2, 16'h0001, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 4'h1, 4'h2, 0, 0);
    alu_a = O_RD_DATA_A; alu_b = O_RD_DATA_B;
    chk("alu_opa", alu_a, 16'h7FFF);
    chk("alu_opb", alu_b, 16'h0001);
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_c   = alu_sum[15:0];
    alu_st  = {alu_c[15], alu_c == 16'h0,
               (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]), 1'b0, alu_sum[16]};
    cyc(0, 1, 1, 4'h3, alu_c, 0, 0, alu_st, 5'h1F);
    cyc(0, 1, 0, 0, 0, 4'h3, 4'h3, 0, 0);
    chk("alu_r3", O_RD_DATA_A, 16'h8000);
    chk("alu_psr", {11'h0, O_PSR}, 16'h0014);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 4) != 0), 1'($urandom),
          4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
          5'($urandom), 5'($urandom));
      chk("rnd_a", O_RD_DATA_A, m_a);
      chk("rnd_b", O_RD_DATA_B, m_b);
      chk("rnd_psr", {11'h0, O_PSR}, {11'h0, m_psr});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
